reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Sequences the Propeller core reset from three sources: PLL lock, the board pushbutton, and the Prop plug reset line. It synchronizes each source into the core clock domain and debounces the pushbutton. It then holds reset for a guaranteed minimum time after all sources release, and drives the registered active-low reset into the p1v core. The block sits in the board top level between the Altera clock generator / pin map and the p1v instance, and replaces the plain AND of the key and plug reset lines.

## Interface
- SYNC_STAGES, 2: synchronizer depth for each asynchronous input; legal range ≥2.
- DB_CYCLES, 160000: pushbutton debounce interval in clock_160 cycles (1 ms at 160 MHz); ≥1.
- HOLD_CYCLES, 1600: minimum reset stretch after release (10 µs); ≥1.
- clock_160  input  1  core clock, single clock domain.
- inp_resn  input  1  asynchronous, active-low global reset (power-on); clears all state.
- pll_locked  input  1  asynchronous PLL lock indicator; high = locked.
- key_n  input  1  asynchronous pushbutton, active-low.
- res_pin  input  1  asynchronous Prop plug reset, active-low.
- resn  output  1  registered active-low reset to the p1v core.
- res_cause  output  2  cause of the most recent reset: 00 power/PLL, 01 key, 10 plug; 11 is never produced.
- res_count  output  8  number of RUN→reset transitions since inp_resn, saturating at 255.

## Operation
- Synchronizers: key_n and res_pin chains reset to 1 (inactive); the pll_locked chain resets to 0.
- key_f is the debounced key (see Configuration); res_s and lock_s are the synchronized values.
- Request vector: lock_req = ~lock_s, plug_req = ~res_s, key_req = ~key_f. An active request is any of these.
- FSM, reset state ACTIVE:
  - ACTIVE: resn=0. When no request is active, go to HOLD and clear the hold counter.
  - HOLD: resn=0. The counter increments each cycle. Any active request returns to ACTIVE. At counter = HOLD_CYCLES-1, go to RUN.
  - RUN: resn=1. Any active request goes to ACTIVE. On that transition, res_cause loads per priority lock (00) > plug (10) > key (01), and res_count increments unless it is already 255.
- res_cause and res_count change only on a RUN→ACTIVE transition. Requests in ACTIVE or HOLD do not update them.
- resn is a flop fed by the next-state decode (next_state==RUN). It has no combinational path from any input.
- Counter widths are $clog2 of their parameter, minimum 1 bit. There is no wrap: the hold counter never exceeds HOLD_CYCLES-1.
- inp_resn asserted at any time forces all of the following, regardless of state: ACTIVE, resn=0, res_cause=00, res_count=0, synchronizers and debounce cleared.

## Timing
- Reset values: resn=0, res_cause=00, res_count=0.
- Release: let cycle 0 be the first cycle with no request in ACTIVE. resn goes high at cycle HOLD_CYCLES+1 and stays high while no request is active.
- Plug assert in RUN: resn goes low SYNC_STAGES+1 edges after res_pin falls (±1 for async sampling).
- Key assert in RUN: with debounce, resn goes low SYNC_STAGES+DB_CYCLES+1 edges after a clean key fall. Without debounce, it is SYNC_STAGES+1.
- Lock loss in RUN: resn goes low SYNC_STAGES+1 edges after pll_locked falls.
- Simultaneous requests on the same cycle use the priority rule, and a single count increment occurs.
- A request glitch during HOLD of even one synchronized cycle restarts the full HOLD_CYCLES interval.

## Configuration
- KEY_DEBOUNCE_EN defined:
  - A DB_CYCLES counter filters the synchronized key.
  - key_f toggles only after the synchronized key has differed from key_f for DB_CYCLES consecutive cycles.
  - The counter clears whenever they are equal. key_f resets to 1.
- Undefined: key_f equals the synchronized key, and no debounce counter or register is synthesized.
- res_pin and pll_locked are never debounced.

## Test plan
Parameters for all scenarios: SYNC_STAGES=2, DB_CYCLES=8, HOLD_CYCLES=4, KEY_DEBOUNCE_EN defined.
- Power-up: release inp_resn with pll_locked=0, then raise pll_locked → resn stays 0 until lock, rises at 2+1+4 edges after the lock edge (±1); res_cause=00, res_count=0.
- Plug pulse: in RUN, drive res_pin low for 3 cycles → resn low 3 edges after the fall; res_cause=10, res_count=1; resn returns high 4 cycles after release is seen.
- Key bounce: toggle key_n low/high every 3 cycles for 30 cycles, then return it high → resn stays 1 and res_count is unchanged. Then hold key_n low for 20 cycles → resn low at edge 11; res_cause=01.
- Simultaneous: drop pll_locked and res_pin on the same edge in RUN → res_cause=00, res_count increments by exactly 1.
- HOLD restart: during HOLD, pulse res_pin low for 1 cycle at hold count 2 → FSM returns to ACTIVE; resn rises only after a fresh full 4-cycle HOLD.
- Saturation and mid-op reset: issue 260 plug resets → res_count=255. Then assert inp_resn during HOLD → resn=0, res_count=0, res_cause=00 immediately (asynchronously).

Source files
------------

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: groups the asynchronous reset sources and the sequenced
// reset outputs of reset_sequencer. The master side is the board (pins, PLL);
// the slave side is the sequencer itself.
`timescale 1ns/1ps

interface reset_sequencer_if;
    logic       pll_locked;  // async PLL lock, high = locked
    logic       key_n;       // async pushbutton, active-low
    logic       res_pin;     // async Prop plug reset, active-low
    logic       resn;        // registered active-low core reset
    logic [1:0] res_cause;   // 00 power/PLL, 01 key, 10 plug
    logic [7:0] res_count;   // RUN->reset transitions, saturating

    modport master (
        output pll_locked, key_n, res_pin,
        input  resn, res_cause, res_count
    );

    modport slave (
        input  pll_locked, key_n, res_pin,
        output resn, res_cause, res_count
    );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronizes PLL lock, pushbutton and plug reset into the
// clock_160 domain, optionally debounces the pushbutton, and stretches the
// core reset for HOLD_CYCLES after every source has released. resn is a flop
// decoded from the next state, so it has no combinational path from any pin.
// Optional feature: define KEY_DEBOUNCE_EN to filter the pushbutton with a
// DB_CYCLES counter; when undefined the synchronized key is used directly.
`timescale 1ns/1ps

module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 160000,
    parameter int HOLD_CYCLES = 1600
) (
    input  logic             clock_160,
    input  logic             inp_resn,
    reset_sequencer_if.slave rs
);

    // Reject illegal parameterizations at elaboration.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("reset_sequencer: SYNC_STAGES must be >= 2");
    end
    if (DB_CYCLES < 1) begin : g_bad_db
        $error("reset_sequencer: DB_CYCLES must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("reset_sequencer: HOLD_CYCLES must be >= 1");
    end

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] CAUSE_PWR  = 2'b00;
    localparam logic [1:0] CAUSE_KEY  = 2'b01;
    localparam logic [1:0] CAUSE_PLUG = 2'b10;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    logic [SYNC_STAGES-1:0] key_sync_q,  key_sync_d;
    logic [SYNC_STAGES-1:0] res_sync_q,  res_sync_d;

    logic lock_s;
    logic key_s;
    logic res_s;
    logic key_f;

    // Shift each asynchronous pin one stage further into the clock domain.
    always_comb begin
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], rs.pll_locked};
        key_sync_d  = {key_sync_q[SYNC_STAGES-2:0],  rs.key_n};
        res_sync_d  = {res_sync_q[SYNC_STAGES-2:0],  rs.res_pin};
    end

    // Synchronizer flops; lock clears to "unlocked", the active-low pins to idle.
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        // NOTE: every flop takes the async clear so inp_resn forces a known state
        // at any moment, independent of the clock.
        if (!inp_resn) begin
            lock_sync_q <= '0;
            key_sync_q  <= '1;
            res_sync_q  <= '1;
        end else begin
            // NOTE: non-blocking assignments so each stage samples the value its
            // neighbour held before the edge; blocking would collapse the chain.
            lock_sync_q <= lock_sync_d;
            key_sync_q  <= key_sync_d;
            res_sync_q  <= res_sync_d;
        end
    end

    assign lock_s = lock_sync_q[SYNC_STAGES-1];
    assign key_s  = key_sync_q[SYNC_STAGES-1];
    assign res_s  = res_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Pushbutton debounce
    // ------------------------------------------------------------------
`ifdef KEY_DEBOUNCE_EN
    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            key_f_q,  key_f_d;

    // Count consecutive cycles the synchronized key disagrees with the filtered
    // key; accept the new level on the DB_CYCLES-th disagreeing cycle.
    always_comb begin
        // NOTE: defaults first so every path assigns every _d (no latch).
        db_cnt_d = '0;
        key_f_d  = key_f_q;
        if (key_s != key_f_q) begin
            if (db_cnt_q == DB_LAST) begin
                key_f_d = key_s;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Debounce state; the filtered key idles released.
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            db_cnt_q <= '0;
            key_f_q  <= 1'b1;
        end else begin
            db_cnt_q <= db_cnt_d;
            key_f_q  <= key_f_d;
        end
    end

    assign key_f = key_f_q;
`else
    assign key_f = key_s;
`endif

    // ------------------------------------------------------------------
    // Reset sequencing FSM
    // ------------------------------------------------------------------
    logic lock_req;
    logic plug_req;
    logic key_req;
    logic any_req;

    assign lock_req = ~lock_s;
    assign plug_req = ~res_s;
    assign key_req  = ~key_f;
    assign any_req  = lock_req | plug_req | key_req;

    state_e            state_q,    state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              resn_q,     resn_d;
    logic [1:0]        cause_q,    cause_d;
    logic [7:0]        count_q,    count_d;

    // Next-state, hold counter and cause/count bookkeeping; resn is decoded
    // from the next state so it changes on the same edge as the state.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        cause_d    = cause_q;
        count_d    = count_q;
        unique case (state_q)
            ST_ACTIVE: begin
                if (!any_req) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (any_req) begin
                    state_d = ST_ACTIVE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (any_req) begin
                    state_d = ST_ACTIVE;
                    if (lock_req) begin
                        cause_d = CAUSE_PWR;
                    end else if (plug_req) begin
                        cause_d = CAUSE_PLUG;
                    end else begin
                        cause_d = CAUSE_KEY;
                    end
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
        resn_d = (state_d == ST_RUN);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            state_q    <= ST_ACTIVE;
            hold_cnt_q <= '0;
            resn_q     <= 1'b0;
            cause_q    <= CAUSE_PWR;
            count_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            resn_q     <= resn_d;
            cause_q    <= cause_d;
            count_q    <= count_d;
        end
    end

    assign rs.resn      = resn_q;
    assign rs.res_cause = cause_q;
    assign rs.res_count = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scenarios for reset_sequencer with
// SYNC_STAGES=2, DB_CYCLES=8, HOLD_CYCLES=4. Inputs change 1 ns after a rising
// edge and outputs are sampled at the same point, away from the active edge.
// Key latencies follow KEY_DEBOUNCE_EN the same way the design does.
`timescale 1ns/1ps

module tb_reset_sequencer;

`ifdef KEY_DEBOUNCE_EN
    localparam int KEY_ASSERT_EDGES  = 11;  // 2 sync + 8 debounce + 1
    localparam int KEY_RELEASE_EDGES = 15;  // 2 sync + 8 debounce + 1 + 4 hold
`else
    localparam int KEY_ASSERT_EDGES  = 3;   // 2 sync + 1
    localparam int KEY_RELEASE_EDGES = 7;   // 2 sync + 1 + 4 hold
`endif

    logic clk;
    logic inp_resn;
    int   n_checks;
    int   n_pass;
    int   exp_count;

    reset_sequencer_if bus ();

    reset_sequencer #(
        .SYNC_STAGES (2),
        .DB_CYCLES   (8),
        .HOLD_CYCLES (4)
    ) dut (
        .clock_160 (clk),
        .inp_resn  (inp_resn),
        .rs        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "tb_reset_sequencer stopped by watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until resn equals val; edges = edge count at which it did, or -1.
    task automatic wait_resn(input logic val, input int max_edges, output int edges);
        edges = -1;
        for (int i = 1; i <= max_edges; i++) begin
            tick();
            if (bus.resn === val) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        inp_resn       = 1'b0;
        bus.pll_locked = 1'b0;
        bus.key_n      = 1'b1;
        bus.res_pin    = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (bus.resn !== 1'b0) $display("FAIL reset_resn: got %b expected 0", bus.resn);
        else n_pass++;
        n_checks++;
        if (bus.res_cause !== 2'b00) $display("FAIL reset_cause: got %b expected 00", bus.res_cause);
        else n_pass++;
        n_checks++;
        if (bus.res_count !== 8'd0) $display("FAIL reset_count: got %0d expected 0", bus.res_count);
        else n_pass++;
        // Release global reset while the PLL is still unlocked.
        inp_resn = 1'b1;
        repeat (10) tick();
        n_checks++;
        if (bus.resn !== 1'b0) $display("FAIL unlocked_resn: got %b expected 0", bus.resn);
        else n_pass++;
    endtask

    task automatic test_power_up();
        int e;
        bus.pll_locked = 1'b1;
        wait_resn(1'b1, 20, e);
        n_checks++;
        if (e != 7) $display("FAIL powerup_rise_edge: got %0d expected 7", e);
        else n_pass++;
        n_checks++;
        if (bus.res_cause !== 2'b00) $display("FAIL powerup_cause: got %b expected 00", bus.res_cause);
        else n_pass++;
        n_checks++;
        if (bus.res_count !== 8'd0) $display("FAIL powerup_count: got %0d expected 0", bus.res_count);
        else n_pass++;
        exp_count = 0;
    endtask

    task automatic test_plug_pulse();
        int e;
        bus.res_pin = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.resn !== 1'b1) $display("FAIL plug_edge2_resn: got %b expected 1", bus.resn);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.resn !== 1'b0) $display("FAIL plug_edge3_resn: got %b expected 0", bus.resn);
        else n_pass++;
        bus.res_pin = 1'b1;
        exp_count++;
        n_checks++;
        if (bus.res_cause !== 2'b10) $display("FAIL plug_cause: got %b expected 10", bus.res_cause);
        else n_pass++;
        n_checks++;
        if (bus.res_count !== 8'(exp_count)) $display("FAIL plug_count: got %0d expected %0d", bus.res_count, exp_count);
        else n_pass++;
        wait_resn(1'b1, 20, e);
        n_checks++;
        if (e != 7) $display("FAIL plug_rise_edge: got %0d expected 7", e);
        else n_pass++;
    endtask

`ifdef KEY_DEBOUNCE_EN
    task automatic test_key_bounce();
        int low_seen;
        low_seen = 0;
        for (int i = 0; i < 10; i++) begin
            bus.key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (3) begin
                tick();
                if (bus.resn !== 1'b1) low_seen++;
            end
        end
        bus.key_n = 1'b1;
        repeat (12) begin
            tick();
            if (bus.resn !== 1'b1) low_seen++;
        end
        n_checks++;
        if (low_seen != 0) $display("FAIL bounce_resn_low_cycles: got %0d expected 0", low_seen);
        else n_pass++;
        n_checks++;
        if (bus.res_count !== 8'(exp_count)) $display("FAIL bounce_count: got %0d expected %0d", bus.res_count, exp_count);
        else n_pass++;
    endtask
`endif

    task automatic test_key_hold();
        int e;
        int rest;
        bus.key_n = 1'b0;
        wait_resn(1'b0, 30, e);
        n_checks++;
        if (e != KEY_ASSERT_EDGES) $display("FAIL key_fall_edge: got %0d expected %0d", e, KEY_ASSERT_EDGES);
        else n_pass++;
        exp_count++;
        n_checks++;
        if (bus.res_cause !== 2'b01) $display("FAIL key_cause: got %b expected 01", bus.res_cause);
        else n_pass++;
        n_checks++;
        if (bus.res_count !== 8'(exp_count)) $display("FAIL key_count: got %0d expected %0d", bus.res_count, exp_count);
        else n_pass++;
        rest = (e > 0 && e < 20) ? 20 - e : 0;
        repeat (rest) tick();
        bus.key_n = 1'b1;
        wait_resn(1'b1, 40, e);
        n_checks++;
        if (e != KEY_RELEASE_EDGES) $display("FAIL key_rise_edge: got %0d expected %0d", e, KEY_RELEASE_EDGES);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        int e;
        bus.pll_locked = 1'b0;
        bus.res_pin    = 1'b0;
        wait_resn(1'b0, 10, e);
        n_checks++;
        if (e != 3) $display("FAIL simul_fall_edge: got %0d expected 3", e);
        else n_pass++;
        exp_count++;
        n_checks++;
        if (bus.res_cause !== 2'b00) $display("FAIL simul_cause: got %b expected 00", bus.res_cause);
        else n_pass++;
        repeat (4) tick();
        n_checks++;
        if (bus.res_count !== 8'(exp_count)) $display("FAIL simul_count: got %0d expected %0d", bus.res_count, exp_count);
        else n_pass++;
        bus.pll_locked = 1'b1;
        bus.res_pin    = 1'b1;
        wait_resn(1'b1, 20, e);
        n_checks++;
        if (e != 7) $display("FAIL simul_rise_edge: got %0d expected 7", e);
        else n_pass++;
        n_checks++;
        if (bus.res_count !== 8'(exp_count)) $display("FAIL simul_count_after: got %0d expected %0d", bus.res_count, exp_count);
        else n_pass++;
    endtask

    task automatic test_hold_restart();
        int e;
        bus.res_pin = 1'b0;
        wait_resn(1'b0, 10, e);
        n_checks++;
        if (e != 3) $display("FAIL restart_fall_edge: got %0d expected 3", e);
        else n_pass++;
        exp_count++;
        repeat (2) tick();
        // Release, then glitch the plug so the synchronized low lands on hold count 2.
        bus.res_pin = 1'b1;
        repeat (3) tick();
        bus.res_pin = 1'b0;
        tick();
        bus.res_pin = 1'b1;
        wait_resn(1'b1, 20, e);
        n_checks++;
        if (e != 7) $display("FAIL restart_rise_edge: got %0d expected 7", e);
        else n_pass++;
        n_checks++;
        if (bus.res_count !== 8'(exp_count)) $display("FAIL restart_count: got %0d expected %0d", bus.res_count, exp_count);
        else n_pass++;
        n_checks++;
        if (bus.res_cause !== 2'b10) $display("FAIL restart_cause: got %b expected 10", bus.res_cause);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int e;
        int timeouts;
        timeouts = 0;
        for (int i = 0; i < 260; i++) begin
            bus.res_pin = 1'b0;
            repeat (3) tick();
            bus.res_pin = 1'b1;
            wait_resn(1'b1, 20, e);
            if (e < 0) timeouts++;
            if (exp_count < 255) exp_count++;
        end
        n_checks++;
        if (timeouts != 0) $display("FAIL sat_run_timeouts: got %0d expected 0", timeouts);
        else n_pass++;
        n_checks++;
        if (bus.res_count !== 8'(exp_count)) $display("FAIL sat_count: got %0d expected %0d", bus.res_count, exp_count);
        else n_pass++;
        n_checks++;
        if (bus.res_cause !== 2'b10) $display("FAIL sat_cause: got %b expected 10", bus.res_cause);
        else n_pass++;
    endtask

    task automatic test_midop_reset();
        int e;
        bus.res_pin = 1'b0;
        repeat (3) tick();
        bus.res_pin = 1'b1;
        repeat (4) tick();  // now in HOLD
        n_checks++;
        if (bus.resn !== 1'b0) $display("FAIL midop_hold_resn: got %b expected 0", bus.resn);
        else n_pass++;
        // Assert global reset between clock edges; outputs must clear without a clock.
        #2;
        inp_resn = 1'b0;
        #1;
        n_checks++;
        if (bus.resn !== 1'b0) $display("FAIL midop_resn: got %b expected 0", bus.resn);
        else n_pass++;
        n_checks++;
        if (bus.res_count !== 8'd0) $display("FAIL midop_count: got %0d expected 0", bus.res_count);
        else n_pass++;
        n_checks++;
        if (bus.res_cause !== 2'b00) $display("FAIL midop_cause: got %b expected 00", bus.res_cause);
        else n_pass++;
        tick();
        inp_resn = 1'b1;
        wait_resn(1'b1, 20, e);
        n_checks++;
        if (e != 7) $display("FAIL midop_rerun_edge: got %0d expected 7", e);
        else n_pass++;
        n_checks++;
        if (bus.res_count !== 8'd0) $display("FAIL midop_rerun_count: got %0d expected 0", bus.res_count);
        else n_pass++;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        exp_count = 0;
        test_reset();
        test_power_up();
        test_plug_pulse();
`ifdef KEY_DEBOUNCE_EN
        test_key_bounce();
`endif
        test_key_hold();
        test_simultaneous();
        test_hold_restart();
        test_saturation();
        test_midop_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
